bus_reg_file: RTL and testbench
===============================

# bus_reg_file

Parametrised register file of NREGS registers, each WIDTH bits, sharing one internal transfer bus, with a command-driven sequencer that performs load, read, move and swap operations. It generalises the two-register, 4-bit bus-transfer datapath to an arbitrary width and register count. It replaces manual per-register in/out strobes with a valid/ready command handshake, so a controller or testbench issues whole transfers instead of driving strobes. Sits between the instruction-decode logic and the datapath registers.

## Interface
- WIDTH, 4, data width of every register and of the bus (1..32)
- NREGS, 4, number of registers (2..16); IW = $clog2(NREGS)
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command this cycle
- cmd_op  input  2  0=LOAD, 1=READ, 2=MOVE, 3=SWAP
- cmd_src  input  IW  source register index (READ/MOVE/SWAP)
- cmd_dst  input  IW  destination register index (LOAD/MOVE/SWAP)
- cmd_data  input  WIDTH  external data for LOAD
- rd_data  output  WIDTH  result of last READ, held
- bus_mon  output  WIDTH  value currently on internal bus, 0 when bus is idle
- done  output  1  one-cycle pulse, command complete
- err  output  1  one-cycle pulse coincident with done, command rejected

## Operation
- Accept on a rising edge with cmd_valid=1 and cmd_ready=1. cmd_src, cmd_dst, cmd_op and cmd_data are captured at acceptance and ignored afterwards.
- cmd_ready=1 only in IDLE.
- At most one driver on the internal bus per cycle: a register, the temp register T, or cmd_data.
- FSM states: IDLE, STEP1, SWAP2, SWAP3.
  - IDLE -> STEP1 on accept.
  - STEP1 -> IDLE for LOAD, READ, MOVE, and for any errored command.
  - STEP1 -> SWAP2 -> SWAP3 -> IDLE for SWAP.
- LOAD: cmd_data on bus; R[dst] <= bus at end of STEP1.
- READ: R[src] on bus; rd_data <= bus at end of STEP1.
- MOVE: R[src] on bus; R[dst] <= bus at end of STEP1. R[src] unchanged.
- SWAP:
  - STEP1: R[src] -> T.
  - SWAP2: R[dst] -> R[src].
  - SWAP3: T -> R[dst].
- src==dst: MOVE and SWAP leave the register unchanged, run their full length and do not raise err.
- Any used index >= NREGS: no register, T or rd_data write; bus_mon=0. FSM goes STEP1 -> IDLE, and done and err pulse together.
- Unused index fields are not checked.
- Reset:
  - all R, T and rd_data = 0; FSM = IDLE.
  - cmd_ready=1; done=0, err=0, bus_mon=0.
  - An in-flight SWAP is aborted, with no partial completion after reset releases.

## Timing
- Edge E0 accepts the command. Each following edge Ek completes step k.
- LOAD, READ, MOVE:
  - write at E1.
  - done high in the cycle after E1; cmd_ready=1 in that same cycle.
  - Sustained throughput: one command per 2 cycles.
- SWAP: writes at E1, E2 and E3; done high in the cycle after E3. Throughput: one command per 4 cycles.
- done and err are registered: high exactly one cycle, never during IDLE without a completed command.
- bus_mon is combinational from the FSM state and registers. It is valid in STEP1, SWAP2 and SWAP3, and 0 otherwise.
- A new command may be accepted in the same cycle done is high; back-to-back commands have no bubble beyond this.
- cmd_valid high while cmd_ready=0 has no effect; the command is not queued.

## Configuration
- BUS_REG_FILE_SWAP_EN defined:
  - SWAP supported as described; T register and SWAP2/SWAP3 states exist.
- BUS_REG_FILE_SWAP_EN undefined:
  - T, SWAP2 and SWAP3 are removed.
  - cmd_op=3 is treated as an error: STEP1 -> IDLE, no writes, done=1 and err=1 after E1.

## Test plan
- Reset, then LOAD dst=0 data=4'hA and LOAD dst=1 data=4'h5 -> R0=A, R1=5; each done exactly 2 cycles after accept; err=0.
- MOVE src=0 dst=1, then READ src=1 -> rd_data=4'hA; bus_mon=4'hA in each STEP1; R0 still A.
- After R0=A and R1=5, SWAP src=0 dst=1 then READ both -> R0=5, R1=A. cmd_ready=0 for 3 cycles after accept; done 4 cycles after accept. Without BUS_REG_FILE_SWAP_EN: done and err after 2 cycles, R0=A and R1=5 unchanged.
- With NREGS=3, MOVE src=3 dst=0 -> err=1 and done=1 after 2 cycles; R0 unchanged. SWAP src=2 dst=2 -> R2 unchanged, err=0.
- Assert rst during SWAP2 -> all registers 0, cmd_ready=1 immediately. No done pulse, no write after release.
- cmd_valid held high for 6 cycles with alternating LOADs -> acceptance exactly every 2 cycles; cmd_data presented while cmd_ready=0 is ignored.

Source files
------------

// File: rtl/bus_reg_file.sv
// Register file on a shared transfer bus with a LOAD/READ/MOVE/SWAP sequencer.
// Define BUS_REG_FILE_SWAP_EN to build in SWAP support (temp register T).
module bus_reg_file #(
  parameter  int WIDTH = 4,
  parameter  int NREGS = 4,
  localparam int IW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [IW-1:0]    cmd_src,
  input  logic [IW-1:0]    cmd_dst,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] bus_mon,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_READ = 2'd1;
  localparam logic [1:0] OP_MOVE = 2'd2;
  localparam logic [1:0] OP_SWAP = 2'd3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_STEP1 = 2'd1;
`ifdef BUS_REG_FILE_SWAP_EN
  localparam logic [1:0] S_SWAP2 = 2'd2;
  localparam logic [1:0] S_SWAP3 = 2'd3;
`endif

  localparam logic [IW:0] NR = NREGS[IW:0];

  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q;
  logic [IW-1:0]    src_q, dst_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] r_q [NREGS];
  logic [WIDTH-1:0] rd_q;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] rsrc;
  logic             src_bad, dst_bad, bad;
  logic             wr_reg, wr_rd;
  logic [IW-1:0]    wr_idx;

`ifdef BUS_REG_FILE_SWAP_EN
  logic [WIDTH-1:0] t_q;
  logic [WIDTH-1:0] rdst;
  logic             wr_t;
`endif

  assign src_bad = {1'b0, src_q} >= NR;
  assign dst_bad = {1'b0, dst_q} >= NR;

  // Only the index fields an op actually uses can reject it.
  always_comb begin
    unique case (op_q)
      OP_LOAD: bad = dst_bad;
      OP_READ: bad = src_bad;
      default: bad = src_bad | dst_bad;
    endcase
`ifndef BUS_REG_FILE_SWAP_EN
    if (op_q == OP_SWAP) bad = 1'b1;
`endif
  end

  always_comb begin
    rsrc = '0;
    for (int i = 0; i < NREGS; i++)
      if (src_q == IW'(i)) rsrc = r_q[i];
  end

`ifdef BUS_REG_FILE_SWAP_EN
  always_comb begin
    rdst = '0;
    for (int i = 0; i < NREGS; i++)
      if (dst_q == IW'(i)) rdst = r_q[i];
  end
`endif

  // Every write takes its value from the bus; one driver per cycle.
  always_comb begin
    bus     = '0;
    wr_reg  = 1'b0;
    wr_rd   = 1'b0;
    wr_idx  = dst_q;
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef BUS_REG_FILE_SWAP_EN
    wr_t    = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: if (cmd_valid) state_d = S_STEP1;
      S_STEP1: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (bad) begin
          err_d = 1'b1;
        end else begin
          unique case (op_q)
            OP_LOAD: begin
              bus    = data_q;
              wr_reg = 1'b1;
            end
            OP_READ: begin
              bus   = rsrc;
              wr_rd = 1'b1;
            end
            OP_MOVE: begin
              bus    = rsrc;
              wr_reg = 1'b1;
            end
            default: begin
`ifdef BUS_REG_FILE_SWAP_EN
              bus     = rsrc;
              wr_t    = 1'b1;
              state_d = S_SWAP2;
              done_d  = 1'b0;
`endif
            end
          endcase
        end
      end
`ifdef BUS_REG_FILE_SWAP_EN
      S_SWAP2: begin
        bus     = rdst;
        wr_reg  = 1'b1;
        wr_idx  = src_q;
        state_d = S_SWAP3;
      end
      S_SWAP3: begin
        bus     = t_q;
        wr_reg  = 1'b1;
        wr_idx  = dst_q;
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NREGS; i++) r_q[i] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (cmd_valid && cmd_ready) begin
        op_q   <= cmd_op;
        src_q  <= cmd_src;
        dst_q  <= cmd_dst;
        data_q <= cmd_data;
      end
      if (wr_rd) rd_q <= bus;
      for (int i = 0; i < NREGS; i++)
        if (wr_reg && wr_idx == IW'(i)) r_q[i] <= bus;
    end
  end

`ifdef BUS_REG_FILE_SWAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       t_q <= '0;
    else if (wr_t) t_q <= bus;
  end
`endif

  assign cmd_ready = (state_q == S_IDLE);
  assign rd_data   = rd_q;
  assign bus_mon   = bus;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bus_reg_file.sv
// Randomised self-checking bench for bus_reg_file (NREGS=3 so index 3 is illegal).
// Follows BUS_REG_FILE_SWAP_EN to pick SWAP or error expectations.
module tb_bus_reg_file;

  localparam int WIDTH = 4;
  localparam int NREGS = 3;
  localparam int IW    = 2;
`ifdef BUS_REG_FILE_SWAP_EN
  localparam bit SWAP_EN = 1'b1;
`else
  localparam bit SWAP_EN = 1'b0;
`endif

  localparam logic [1:0] LOAD = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] MOVE = 2'd2;
  localparam logic [1:0] SWAP = 2'd3;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [IW-1:0]    cmd_src;
  logic [IW-1:0]    cmd_dst;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] bus_mon;
  logic             done;
  logic             err;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] m [NREGS];
  logic [WIDTH-1:0] mrd;

  bus_reg_file #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .cmd_data(cmd_data), .rd_data(rd_data), .bus_mon(bus_mon),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Issue one command from a negedge; returns on the negedge where done is due.
  task automatic issue(input logic [1:0] op, input int src,
                       input int dst, input logic [WIDTH-1:0] data);
    logic bad;
    int lat;
    int w;
    logic [WIDTH-1:0] rs, rdv, erd;
    logic [WIDTH-1:0] eb [4];
    bad = 1'b0;
    if (op != LOAD && src >= NREGS) bad = 1'b1;
    if (op != READ && dst >= NREGS) bad = 1'b1;
    if (op == SWAP && !SWAP_EN) bad = 1'b1;
    lat = (op == SWAP && !bad) ? 4 : 2;
    rs  = (src < NREGS) ? m[src] : '0;
    rdv = (dst < NREGS) ? m[dst] : '0;
    eb[0] = '0;
    eb[1] = bad ? '0 : ((op == LOAD) ? data : rs);
    eb[2] = rdv;
    eb[3] = rs;
    erd = (op == READ && !bad) ? rs : mrd;
    w = 0;
    while (!cmd_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL wait_ready: cmd_ready=%b required 1", cmd_ready);
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_src   = IW'(src);
    cmd_dst   = IW'(dst);
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = WIDTH'($urandom);
    cmd_src   = IW'($urandom);
    cmd_dst   = IW'($urandom);
    for (int k = 1; k <= lat; k++) begin
      checks++;
      if (done !== (k == lat) || err !== (k == lat && bad)) begin
        errors++;
        $display("FAIL done_err op=%0d k=%0d: done=%b err=%b required %b %b",
                 op, k, done, err, k == lat, k == lat && bad);
      end
      checks++;
      if (cmd_ready !== (k == lat)) begin
        errors++;
        $display("FAIL ready op=%0d k=%0d: cmd_ready=%b required %b",
                 op, k, cmd_ready, k == lat);
      end
      checks++;
      if (bus_mon !== ((k < lat) ? eb[k] : '0)) begin
        errors++;
        $display("FAIL bus op=%0d k=%0d: bus_mon=%h required %h",
                 op, k, bus_mon, (k < lat) ? eb[k] : '0);
      end
      if (k < lat) @(negedge clk);
    end
    if (!bad) begin
      unique case (op)
        LOAD: m[dst] = data;
        READ: mrd = rs;
        MOVE: m[dst] = rs;
        default: begin
          m[src] = rdv;
          m[dst] = rs;
        end
      endcase
    end
    checks++;
    if (rd_data !== erd) begin
      errors++;
      $display("FAIL rd_data op=%0d: rd_data=%h required %h", op, rd_data, erd);
    end
  endtask

  task automatic read_all();
    for (int i = 0; i < NREGS; i++) issue(READ, i, 0, '0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_src = '0;
    cmd_dst = '0;
    cmd_data = '0;
    for (int i = 0; i < NREGS; i++) m[i] = '0;
    mrd = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 ||
        bus_mon !== '0 || rd_data !== '0) begin
      errors++;
      $display("FAIL reset: ready=%b done=%b err=%b bus=%h rd=%h required 1 0 0 0 0",
               cmd_ready, done, err, bus_mon, rd_data);
    end
    rst = 1'b0;
    @(negedge clk);
    read_all();
  endtask

  task automatic test_load_move_read();
    issue(LOAD, 0, 0, 4'hA);
    issue(LOAD, 0, 1, 4'h5);
    issue(MOVE, 0, 1, '0);
    issue(READ, 1, 0, '0);
    checks++;
    if (rd_data !== 4'hA) begin
      errors++;
      $display("FAIL move_read: rd_data=%h required a", rd_data);
    end
    issue(READ, 0, 0, '0);
  endtask

  task automatic test_swap();
    issue(LOAD, 0, 0, 4'hA);
    issue(LOAD, 0, 1, 4'h5);
    issue(SWAP, 0, 1, '0);
    issue(READ, 0, 0, '0);
    checks++;
    if (rd_data !== (SWAP_EN ? 4'h5 : 4'hA)) begin
      errors++;
      $display("FAIL swap_r0: rd_data=%h required %h", rd_data,
               SWAP_EN ? 4'h5 : 4'hA);
    end
    issue(READ, 1, 0, '0);
  endtask

  task automatic test_errors();
    issue(MOVE, 3, 0, '0);
    issue(LOAD, 0, 3, 4'h7);
    issue(READ, 3, 0, '0);
    issue(LOAD, 0, 2, 4'hC);
    issue(SWAP, 2, 2, '0);
    issue(MOVE, 2, 2, '0);
    read_all();
  endtask

  task automatic test_reset_mid_swap();
    issue(LOAD, 0, 0, 4'h3);
    issue(LOAD, 0, 1, 4'h9);
    cmd_valid = 1'b1;
    cmd_op = SWAP;
    cmd_src = 2'd0;
    cmd_dst = 2'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || bus_mon !== '0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL rst_swap: ready=%b bus=%h done=%b err=%b required 1 0 0 0",
               cmd_ready, bus_mon, done, err);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREGS; i++) m[i] = '0;
    mrd = '0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (done !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL rst_after k=%0d: done=%b err=%b required 0 0", k, done, err);
      end
      @(negedge clk);
    end
    read_all();
  endtask

  task automatic test_back_to_back();
    int d;
    logic [WIDTH-1:0] v;
    @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      d = (c / 2) % NREGS;
      v = WIDTH'($urandom);
      cmd_valid = 1'b1;
      cmd_op    = LOAD;
      cmd_dst   = IW'(d);
      cmd_data  = v;
      checks++;
      if (cmd_ready !== (c % 2 == 0) || done !== (c > 0 && c % 2 == 0) || err !== 1'b0) begin
        errors++;
        $display("FAIL b2b c=%0d: ready=%b done=%b err=%b required %b %b 0",
                 c, cmd_ready, done, err, c % 2 == 0, c > 0 && c % 2 == 0);
      end
      if (c % 2 == 0) m[d] = v;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_last: done=%b required 1", done);
    end
    read_all();
  endtask

  task automatic test_random();
    logic [1:0] op;
    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom);
      issue(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            WIDTH'($urandom));
    end
    read_all();
  endtask

  initial begin
    test_reset();
    test_load_move_read();
    test_swap();
    test_errors();
    test_reset_mid_swap();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
